// File: rtl/led_pattern_sched.sv
// led_pattern_sched: steps a 4-LED pattern at a programmable rate under cmd/run/stop control
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   cmd_valid/ready mode command handshake; cmd_mode sampled on accept
//   run             level; 1 = stepping allowed, 0 = hold the current step
//   stop            forces IDLE (wins over a command offered in the same cycle)
//   leds            LED drive, 1 = lit
//   step_tick       one-cycle pulse in the cycle leds shows a new step
//   busy            high whenever the controller is not idle
module led_pattern_sched #(
   parameter int STEP_CYCLES = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   input  logic [1:0] cmd_mode,
   output logic       cmd_ready,
   input  logic       run,
   input  logic       stop,
   output logic [3:0] leds,
   output logic       step_tick,
   output logic       busy
);
   localparam int PW = $clog2(STEP_CYCLES);
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_PAUSE} state_t;
   state_t          r_state;
   logic [1:0]      r_mode;
   logic [3:0]      r_idx;
   logic [PW-1:0]   r_pcnt;
   logic [3:0]      r_leds;
   logic            r_tick;
   logic            r_busy;
   logic            w_accept;
   logic            w_last;
   logic [3:0]      w_idx_nxt;
   function automatic logic [3:0] f_pat(input logic [1:0] m, input logic [3:0] i);
      return m == 2'd0 ? ~(4'b0001 << i[1:0]) :
             m == 2'd1 ?  (4'b0001 << i[1:0]) :
             m == 2'd2 ? {4{~i[0]}} : i;
   endfunction
   assign cmd_ready = r_state != S_LOAD;
   assign w_accept  = cmd_valid && cmd_ready;
   assign w_last    = r_pcnt == PW'(STEP_CYCLES - 1);
   // wrap the step index at the length of the active pattern
   assign w_idx_nxt = r_mode == 2'd3 ? r_idx + 4'd1 :
                      r_mode == 2'd2 ? {3'b000, ~r_idx[0]} :
                                       {2'b00, r_idx[1:0] + 2'd1};
   assign leds      = r_leds;
   assign step_tick = r_tick;
   assign busy      = r_busy;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_mode  <= 2'd0;
         r_idx   <= 4'd0;
         r_pcnt  <= '0;
         r_leds  <= 4'b1111;
         r_tick  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_tick <= 1'b0;
         if (stop) begin
            r_state <= S_IDLE;
            r_idx   <= 4'd0;
            r_pcnt  <= '0;
            r_leds  <= 4'b1111;
            r_busy  <= 1'b0;
         end else if (w_accept) begin
            r_state <= S_LOAD;
            r_mode  <= cmd_mode;
            r_busy  <= 1'b1;
         end else if (r_state == S_LOAD) begin
            r_idx   <= 4'd0;
            r_pcnt  <= '0;
            r_leds  <= f_pat(r_mode, 4'd0);
            r_state <= run ? S_RUN : S_PAUSE;
         end else if (r_state != S_IDLE && run) begin
            // a PAUSE cycle that sees run return already counts, so a pause
            // stretches the step by exactly the cycles spent paused
            r_state <= S_RUN;
            if (w_last) begin
               r_pcnt <= '0;
               r_idx  <= w_idx_nxt;
               r_leds <= f_pat(r_mode, w_idx_nxt);
               r_tick <= 1'b1;
            end else begin
               r_pcnt <= r_pcnt + PW'(1);
            end
         end else if (r_state != S_IDLE) begin
            r_state <= S_PAUSE;
         end
      end
   end
endmodule

// File: tb/tb_led_pattern_sched.sv
// tb_led_pattern_sched: scoreboard bench for led_pattern_sched with STEP_CYCLES=4
module tb_led_pattern_sched;
   typedef struct {int cyc; logic [3:0] leds;} tick_t;
   typedef struct {int cyc; logic [6:0] exp; string name;} snap_t;
   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic [1:0] cmd_mode;
   logic       cmd_ready;
   logic       run;
   logic       stop;
   logic [3:0] leds;
   logic       step_tick;
   logic       busy;
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_bad = 0;
   bit         done = 1'b0;
   tick_t      tq[$];
   snap_t      sq[$];
   led_pattern_sched #(.STEP_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_mode(cmd_mode),
      .cmd_ready(cmd_ready), .run(run), .stop(stop), .leds(leds),
      .step_tick(step_tick), .busy(busy)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask
   task automatic push_tick(input int c, input logic [3:0] l);
      tq.push_back('{c, l});
   endtask
   // snapshot vector is {leds, cmd_ready, busy, step_tick}
   task automatic push_snap(input int c, input logic [6:0] e, input string nm);
      sq.push_back('{c, e, nm});
   endtask
   // offer a command for one cycle from a negedge; accept edge returned in n
   task automatic issue(input logic [1:0] m, input logic [3:0] prev, input logic [3:0] first, output int n);
      n = cyc + 1;
      cmd_valid = 1'b1;
      cmd_mode  = m;
      push_snap(n, {prev, 3'b010}, "load");
      push_snap(n + 1, {first, 3'b110}, "first_pattern");
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask
   initial begin
      int n;
      int d;
      logic [3:0] t1 [4];
      rst = 1'b1; cmd_valid = 1'b0; cmd_mode = 2'd0; run = 1'b0; stop = 1'b0;
      t1 = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
      push_snap(2, {4'b1111, 3'b100}, "reset");
      wait_until(2);
      rst = 1'b0;
      wait_until(3);
      run = 1'b1;
      issue(2'd0, 4'b1111, 4'b1110, n);
      for (int k = 0; k < 4; k++) push_tick(n + 5 + 4 * k, t1[k]);
      wait_until(n + 18);
      issue(2'd3, 4'b1110, 4'b0000, n);
      for (int k = 1; k <= 17; k++) push_tick(n + 1 + 4 * k, 4'(k));
      wait_until(n + 70);
      issue(2'd1, 4'b0001, 4'b0001, n);
      push_tick(n + 5, 4'b0010);
      wait_until(n + 7);
      run = 1'b0;
      push_snap(n + 10, {4'b0010, 3'b110}, "pause_hold");
      wait_until(n + 12);
      run = 1'b1;
      push_tick(n + 14, 4'b0100);
      push_tick(n + 18, 4'b1000);
      push_tick(n + 22, 4'b0001);
      wait_until(n + 23);
      issue(2'd0, 4'b0001, 4'b1110, n);
      push_tick(n + 5, 4'b1101);
      wait_until(n + 8);
      issue(2'd2, 4'b1101, 4'b1111, d);
      push_tick(d + 5, 4'b0000);
      push_tick(d + 9, 4'b1111);
      wait_until(d + 10);
      stop = 1'b1; cmd_valid = 1'b1; cmd_mode = 2'd3;
      push_snap(d + 11, {4'b1111, 3'b100}, "stop_vs_cmd");
      @(negedge clk);
      stop = 1'b0; cmd_valid = 1'b0;
      push_snap(d + 20, {4'b1111, 3'b100}, "idle_ignores_run");
      wait_until(d + 22);
      issue(2'd3, 4'b1111, 4'b0000, n);
      push_tick(n + 5, 4'b0001);
      push_tick(n + 9, 4'b0010);
      wait_until(n + 10);
      rst = 1'b1;
      push_snap(n + 11, {4'b1111, 3'b100}, "mid_reset");
      @(negedge clk);
      rst = 1'b0;
      issue(2'd0, 4'b1111, 4'b1110, n);
      push_tick(n + 5, 4'b1101);
      wait_until(n + 8);
      done = 1'b1;
   end
   always @(negedge clk) begin
      while (tq.size() > 0 && tq[0].cyc < cyc) begin
         n_cmp++; n_bad++;
         $display("FAIL tick_missing cyc=%0d: no step_tick, required leds=%b", tq[0].cyc, tq[0].leds);
         tq.delete(0);
      end
      if (step_tick) begin
         n_cmp++;
         if (tq.size() > 0 && tq[0].cyc == cyc) begin
            if (leds !== tq[0].leds) begin
               n_bad++;
               $display("FAIL tick_leds cyc=%0d: got %b required %b", cyc, leds, tq[0].leds);
            end
            tq.delete(0);
         end else begin
            n_bad++;
            $display("FAIL tick_unexpected cyc=%0d: got step_tick=1 leds=%b required no tick", cyc, leds);
         end
      end
      foreach (sq[i]) if (sq[i].cyc == cyc) begin
         n_cmp++;
         if ({leds, cmd_ready, busy, step_tick} !== sq[i].exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d: got {leds,ready,busy,tick}=%b required %b",
                     sq[i].name, cyc, {leds, cmd_ready, busy, step_tick}, sq[i].exp);
         end
      end
      while (sq.size() > 0 && sq[0].cyc <= cyc) sq.delete(0);
      if (done || cyc > 5000) begin
         if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout cyc=%0d: got no end of stimulus required by cycle 5000", cyc);
         end
         foreach (tq[i]) begin
            n_cmp++; n_bad++;
            $display("FAIL tick_missing cyc=%0d: no step_tick, required leds=%b", tq[i].cyc, tq[i].leds);
         end
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
         $finish;
      end
   end
endmodule
